// File: rtl/device_event_arbiter_pkg.sv
// rtl/device_event_arbiter_pkg.sv - shared FSM encoding and default sizing for the device event arbiter
package device_event_arbiter_pkg;

    // Default number of device requesters.
    localparam int DEFAULT_NUM_DEV = 4;

    // Arbiter FSM: IDLE may grant, HOLD is the mandatory one-cycle gap after a grant.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // Width of a device index / round-robin pointer.
    function automatic int ptr_width(input int num_dev);
        return (num_dev > 1) ? $clog2(num_dev) : 1;
    endfunction

endpackage

// File: rtl/device_event_arbiter_rr_pick.sv
// rtl/device_event_arbiter_rr_pick.sv - combinational round-robin winner selection starting at ptr
module rr_pick
    import device_event_arbiter_pkg::*;
#(
    parameter int NUM_DEV = DEFAULT_NUM_DEV,
    parameter int PW      = ptr_width(NUM_DEV)
) (
    input  logic [NUM_DEV-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_DEV-1:0] grant,
    output logic               valid
);

    int idx;

    // Scan ptr, ptr+1, ... wrapping, and take the first requester found.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_DEV; i++) begin
            idx = (int'(ptr) + i) % NUM_DEV;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/device_event_arbiter.sv
// rtl/device_event_arbiter.sv - round-robin device event arbiter feeding an on/off monitor counter (option: ARB_REDUNDANT_FILTER_EN)
module device_event_arbiter
    import device_event_arbiter_pkg::*;
#(
    parameter int NUM_DEV = DEFAULT_NUM_DEV
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_DEV-1:0] req,
    input  logic [NUM_DEV-1:0] req_dir,
    output logic [NUM_DEV-1:0] ack,
    output logic               change,
    output logic               on_off,
    output logic [NUM_DEV-1:0] active_map,
    output logic               busy
);

    localparam int PW = ptr_width(NUM_DEV);

    arb_state_t         state;
    logic [PW-1:0]      ptr;
    logic [NUM_DEV-1:0] pick_grant;
    logic               pick_valid;
    logic [PW-1:0]      winner;
    logic [PW-1:0]      next_ptr;
    logic               grant_change;

    rr_pick #(
        .NUM_DEV (NUM_DEV),
        .PW      (PW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    // Encode the one-hot pick as an index and derive the pointer that follows it.
    always_comb begin
        winner = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (pick_grant[i]) begin
                winner = PW'(i);
            end
        end
        if (winner == PW'(NUM_DEV - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = winner + 1'b1;
        end
    end

`ifdef ARB_REDUNDANT_FILTER_EN
    // A grant that does not alter the device's recorded state is acked silently.
    always_comb begin
        grant_change = (req_dir[winner] != active_map[winner]);
    end
`else
    // Every grant reports a change to the monitor counter.
    always_comb begin
        grant_change = 1'b1;
    end
`endif

    // Two-state arbiter: grant from IDLE, then one forced HOLD cycle before the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            ack        <= '0;
            change     <= 1'b0;
            on_off     <= 1'b0;
            active_map <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state              <= HOLD;
                        ack                <= pick_grant;
                        change             <= grant_change;
                        on_off             <= req_dir[winner];
                        active_map[winner] <= req_dir[winner];
                        ptr                <= next_ptr;
                    end else begin
                        ack    <= '0;
                        change <= 1'b0;
                    end
                end
                HOLD: begin
                    state  <= IDLE;
                    ack    <= '0;
                    change <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    ack    <= '0;
                    change <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state == HOLD);

endmodule

// File: tb/tb_device_event_arbiter.sv
// tb/tb_device_event_arbiter.sv - self-checking bench for device_event_arbiter against a behavioural model
module tb_device_event_arbiter;

    localparam int N = 4;

`ifdef ARB_REDUNDANT_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] req_dir;
    logic [N-1:0] ack;
    logic         change;
    logic         on_off;
    logic [N-1:0] active_map;
    logic         busy;

    int total = 0;
    int bad   = 0;

    bit           m_hold;
    int           m_ptr;
    logic [N-1:0] m_active;
    logic [N-1:0] m_ack;
    logic         m_change;
    logic         m_onoff;
    int           waitc [N];

    logic [N-1:0] pend;
    logic [N-1:0] pdir;
    logic [N-1:0] drive_dir;
    logic [N-1:0] fair_exp [9];

    always #5 clk = ~clk;

    device_event_arbiter #(.NUM_DEV(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_dir    (req_dir),
        .ack        (ack),
        .change     (change),
        .on_off     (on_off),
        .active_map (active_map),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what one rising edge must do given the inputs presented to it.
    task automatic model_edge(input logic r, input logic [N-1:0] q, input logic [N-1:0] d);
        int w;
        for (int j = 0; j < N; j++) if (!q[j]) waitc[j] = 0;
        if (r) begin
            m_hold = 0; m_ptr = 0; m_active = '0; m_ack = '0; m_change = 0; m_onoff = 0;
            for (int j = 0; j < N; j++) waitc[j] = 0;
        end else if (m_hold) begin
            m_hold = 0; m_ack = '0; m_change = 0;
        end else if (q != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && q[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            chk("starvation", 32'(waitc[w] < N), 32'd1);
            for (int j = 0; j < N; j++) if (q[j] && j != w) waitc[j]++;
            waitc[w]    = 0;
            m_ack       = '0;
            m_ack[w]    = 1'b1;
            m_onoff     = d[w];
            m_change    = FILT ? (d[w] != m_active[w]) : 1'b1;
            m_active[w] = d[w];
            m_ptr       = (w + 1) % N;
            m_hold      = 1;
        end else begin
            m_ack = '0; m_change = 0;
        end
    endtask

    // One clock: drive at negedge, advance the model, compare every output after the edge.
    task automatic step(input logic r, input logic [N-1:0] q, input logic [N-1:0] d);
        @(negedge clk);
        rst = r; req = q; req_dir = d;
        model_edge(r, q, d);
        @(posedge clk);
        #1;
        chk("ack", 32'(ack), 32'(m_ack));
        chk("change", 32'(change), 32'(m_change));
        chk("on_off", 32'(on_off), 32'(m_onoff));
        chk("active_map", 32'(active_map), 32'(m_active));
        chk("busy", 32'(busy), 32'(m_hold));
    endtask

    initial begin
        rst = 1'b1; req = '0; req_dir = '0;

        // Reset held two cycles with all requests high.
        step(1, 4'b1111, 4'b1111);
        step(1, 4'b1111, 4'b1111);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_change", 32'(change), 32'h0);
        chk("rst_active", 32'(active_map), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Single device turning on; then pointer must sit at 3.
        step(0, 4'b0100, 4'b0100);
        chk("single_ack", 32'(ack), 32'h4);
        chk("single_change", 32'(change), 32'h1);
        chk("single_onoff", 32'(on_off), 32'h1);
        chk("single_active", 32'(active_map), 32'h4);
        step(0, 4'b1111, 4'b1111);
        chk("gap_ack", 32'(ack), 32'h0);
        step(0, 4'b1111, 4'b1111);
        chk("ptr3_ack", 32'(ack), 32'h8);

        // Fairness with all requests held.
        fair_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                     4'b0000, 4'b1000, 4'b0000, 4'b0001};
        step(1, 4'b0000, 4'b0000);
        for (int i = 0; i < 9; i++) begin
            step(0, 4'b1111, 4'b1111);
            chk($sformatf("fair_ack%0d", i), 32'(ack), 32'(fair_exp[i]));
        end

        // Pointer wrap from 3.
        step(1, 4'b0000, 4'b0000);
        step(0, 4'b0100, 4'b0100);
        step(0, 4'b0000, 4'b0000);
        step(0, 4'b1001, 4'b1001);
        chk("wrap_ack_hi", 32'(ack), 32'h8);
        step(0, 4'b0001, 4'b0001);
        step(0, 4'b0001, 4'b0001);
        chk("wrap_ack_lo", 32'(ack), 32'h1);

        // Device 1 turned on twice.
        step(1, 4'b0000, 4'b0000);
        step(0, 4'b0010, 4'b0010);
        chk("filt_first_change", 32'(change), 32'h1);
        step(0, 4'b0000, 4'b0000);
        step(0, 4'b0010, 4'b0010);
        chk("filt_second_ack", 32'(ack), 32'h2);
        chk("filt_second_change", 32'(change), FILT ? 32'h0 : 32'h1);

        // Reset during HOLD cancels the grant's effects.
        step(1, 4'b0000, 4'b0000);
        step(0, 4'b0001, 4'b0001);
        chk("mid_grant_ack", 32'(ack), 32'h1);
        step(1, 4'b0001, 4'b0001);
        chk("mid_rst_ack", 32'(ack), 32'h0);
        chk("mid_rst_change", 32'(change), 32'h0);
        chk("mid_rst_active", 32'(active_map), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        step(0, 4'b0010, 4'b0010);
        chk("post_rst_ack", 32'(ack), 32'h2);

        // Randomized requesters that hold req until acked.
        step(1, 4'b0000, 4'b0000);
        pend = '0; pdir = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic r;
            r = ($urandom_range(0, 299) == 0);
            pend = pend & ~m_ack;
            for (int j = 0; j < N; j++) begin
                if (!pend[j] && !m_ack[j] && ($urandom_range(0, 2) == 0)) begin
                    pend[j] = 1'b1;
                    pdir[j] = 1'($urandom_range(0, 1));
                end
            end
            drive_dir = 4'($urandom);
            for (int j = 0; j < N; j++) if (pend[j]) drive_dir[j] = pdir[j];
            step(r, pend, drive_dir);
            if (r) pend = '0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/device_event_arbiter.md
DEVICE_EVENT_ARBITER -- requirements
Module: device_event_arbiter

Interface
REQ-001 Parameter: NUM_DEV, default 4, number of IoT device requesters (2..8).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 Port: req  input  NUM_DEV  per-device event request, level, held until acked.
REQ-005 Port: req_dir  input  NUM_DEV  per-device event direction, 1=turned on, 0=turned off; valid while req high.
REQ-006 Port: ack  output  NUM_DEV  one-hot grant pulse, registered, one cycle.
REQ-007 Port: change  output  1  registered strobe to monitor counter change input.
REQ-008 Port: on_off  output  1  registered direction to monitor counter on_off input.
REQ-009 Port: active_map  output  NUM_DEV  registered bitmap of devices currently on.
REQ-010 Port: busy  output  1  high while FSM is in HOLD.

Function
REQ-011 FSM shall have two states: IDLE and HOLD; reset state IDLE.
REQ-012 In IDLE with any req bit high at an edge, arbiter shall select one winner by round-robin from pointer ptr, move to HOLD, assert ack[winner]=1 for exactly the following cycle.
REQ-013 Round-robin: search order ptr, ptr+1, ..., wrapping modulo NUM_DEV; after a grant ptr shall become (winner+1) mod NUM_DEV.
REQ-014 In IDLE with req all zero, FSM shall stay IDLE, ack=0, change=0, ptr unchanged.
REQ-015 HOLD shall last exactly one cycle, then return to IDLE unconditionally; no grant is issued from HOLD, giving a guaranteed one-cycle gap so a requester can drop req after seeing ack.
REQ-016 Grant latency: req sampled high at edge k, ack and change visible after edge k; next grant no earlier than after edge k+2.
REQ-017 On a grant, on_off shall equal req_dir[winner]; change shall be 1 unless suppressed per REQ-024; change and on_off shall be valid in the same cycle as ack.
REQ-018 change shall be 0 in every cycle without a grant; on_off shall hold its last value when change=0.
REQ-019 active_map[winner] shall be updated to req_dir[winner] on every grant, in the same edge as ack.
REQ-020 Simultaneous requests: exactly one ack bit per grant; losers keep req high and are served in later IDLE cycles; no requester starves longer than NUM_DEV grants.

Reset
REQ-021 rst=1 at an edge shall force state=IDLE, ptr=0, ack=0, change=0, on_off=0, active_map=0, busy=0.
REQ-022 rst shall take priority over any grant, including mid-HOLD; an in-flight ack is cancelled in the following cycle.
REQ-023 First grant after reset release shall follow REQ-012 with ptr=0.

Configuration
REQ-024 Macro ARB_REDUNDANT_FILTER_EN: when defined, a grant where req_dir[winner]==active_map[winner] shall still ack but drive change=0; when undefined, every grant drives change=1.

Structure
REQ-025 Shared package shall hold the FSM state encoding (IDLE, HOLD) and default NUM_DEV constant.
REQ-026 Round-robin winner selection shall be a sub-module rr_pick (combinational: req, ptr -> one-hot grant, valid).

Verification
REQ-027 Reset: rst=1 two cycles with req=4'b1111 -> ack=0, change=0, active_map=0, busy=0.
REQ-028 Single on: req=4'b0100, req_dir=4'b0100 from IDLE, ptr=0 -> next cycle ack=4'b0100, change=1, on_off=1, active_map=4'b0100; ptr=3.
REQ-029 Fairness: req=4'b1111 held, all req_dir=1 -> ack order 0001, 0010, 0100, 1000, 0001 on alternating cycles.
REQ-030 Pointer wrap: ptr=3, req=4'b1001 -> ack=4'b1000 then 4'b0001.
REQ-031 Filter: with ARB_REDUNDANT_FILTER_EN, device 1 on twice -> first grant change=1, second ack=4'b0010 with change=0; without macro both change=1.
REQ-032 Reset mid-HOLD: rst=1 in cycle after grant -> ack=0, change=0, active_map=0 next cycle, state IDLE.
